// File: rtl/sha512_pkg.sv
// sha512_pkg -- shared types for the SHA-512 memory responder slice.
//
// Holds a minimal CCI-P subset (cache-line address, burst length, request
// and response channel structs) together with the responder FSM state type
// and its sizing constants.
//
// Request handshake: a channel request is offered by raising valid for one
// cycle; there is no ready. The responder accepts every request it can and
// raises c0TxAlmFull early enough that a well-behaved requester stops before
// the read queue overflows. Responses are pushed with rspValid and must be
// consumed in the cycle they appear.
package sha512_pkg;

  // Latency counter width; RD_LATENCY must fit, so 1..15.
  localparam int RSP_LAT_W    = 4;
  // Largest read-queue depth the responder is intended to be built with.
  localparam int RSP_MAX_FIFO = 16;

  typedef enum logic [1:0] {
    S_RSP_IDLE = 2'd0,
    S_RSP_WAIT = 2'd1,
    S_RSP_SEND = 2'd2
  } t_rsp_state;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [1:0]   t_ccip_clNum;

  // Encoded burst length: number of lines is cl_len + 1.
  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_clLen  cl_len;
    t_ccip_clAddr address;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_clAddr address;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_rsp resp_type;
    t_ccip_clNum  cl_num;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

endpackage

// File: rtl/sha512_req_fifo.sv
// sha512_req_fifo -- small synchronous FIFO holding queued read requests.
//
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width in bits).
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   push        write push_data this cycle (ignored when full)
//   push_data   entry to enqueue
//   pop         drop the head entry this cycle (ignored when empty)
//   pop_data    current head entry (valid while !empty)
//   count       current occupancy, 0..DEPTH
//   full/empty  occupancy == DEPTH / occupancy == 0
// Push and pop together leave the occupancy unchanged.
module sha512_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = buf_q[rd_ptr_q];
  assign count    = count_q;

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sha512_mem_responder.sv
// sha512_mem_responder -- behavioural CCI-P host-memory responder.
//
// Models a window of MEM_LINES 512-bit lines starting at cache-line address
// MEM_BASE. Reads on c0 are queued, then answered after RD_LATENCY cycles
// as one beat per line; writes on c1 update memory at once and are
// acknowledged the following cycle. Any access outside the window sets the
// sticky addr_err, as does a read offered while the queue is full (that
// read is dropped).
//
// Parameters: MEM_BASE, MEM_LINES, RD_LATENCY (1..15), FIFO_DEPTH (pow2 >= 2).
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   ccip_c0_tx   read requests  (valid, hdr.address, hdr.cl_len)
//   ccip_c1_tx   write requests (valid, hdr.address, data)
//   ccip_rx      c0 read beats, c1 write acks, c0TxAlmFull, c1TxAlmFull
//   addr_err     sticky error flag, cleared only by reset
//   rsp_state    current response FSM state (debug)
//
// Build option: define SHA512_RSP_REORDER_EN to emit multi-line bursts in
// descending cl_num order; otherwise bursts are ascending.
module sha512_mem_responder
  import sha512_pkg::*;
#(
  parameter t_ccip_clAddr MEM_BASE   = '0,
  parameter int           MEM_LINES  = 64,
  parameter int           RD_LATENCY = 2,
  parameter int           FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  t_if_ccip_c0_Tx ccip_c0_tx,
  input  t_if_ccip_c1_Tx ccip_c1_tx,
  output t_if_ccip_Rx    ccip_rx,
  output logic           addr_err,
  output t_rsp_state     rsp_state
);

  localparam int MEM_AW = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HDR_W  = $bits(t_ccip_c0_ReqMemHdr);
  localparam t_ccip_clAddr         LINES_A  = t_ccip_clAddr'(MEM_LINES);
  localparam logic [RSP_LAT_W-1:0] LAT_LOAD = RSP_LAT_W'(RD_LATENCY - 1);

  t_ccip_clData mem [MEM_LINES];

  // ---------------- read request queue ----------------
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [HDR_W-1:0]   fifo_head;
  t_ccip_c0_ReqMemHdr head_hdr;

  assign fifo_push = ccip_c0_tx.valid && !fifo_full;
  assign head_hdr  = t_ccip_c0_ReqMemHdr'(fifo_head);

  sha512_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HDR_W)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ccip_c0_tx.hdr),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- response FSM ----------------
  t_rsp_state           state_q, state_d;
  logic [RSP_LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  t_ccip_clAddr         cur_addr_q, cur_addr_d;
  logic [1:0]           cur_len_q, cur_len_d;
  logic [1:0]           beat_q, beat_d;
  logic                 beat_valid;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    cur_addr_d = cur_addr_q;
    cur_len_d  = cur_len_q;
    beat_d     = beat_q;
    fifo_pop   = 1'b0;
    beat_valid = 1'b0;
    case (state_q)
      S_RSP_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_addr_d = head_hdr.address;
          cur_len_d  = head_hdr.cl_len;
          lat_cnt_d  = LAT_LOAD;
          beat_d     = '0;
          state_d    = S_RSP_WAIT;
        end
      end
      S_RSP_WAIT: begin
        // The counter reaches 0 on this edge (or already sits there when
        // RD_LATENCY is 1), so the first beat appears next cycle.
        if (lat_cnt_q <= RSP_LAT_W'(1)) begin
          lat_cnt_d = '0;
          beat_d    = '0;
          state_d   = S_RSP_SEND;
        end else begin
          lat_cnt_d = lat_cnt_q - RSP_LAT_W'(1);
        end
      end
      S_RSP_SEND: begin
        beat_valid = 1'b1;
        if (beat_q == cur_len_q) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            cur_addr_d = head_hdr.address;
            cur_len_d  = head_hdr.cl_len;
            lat_cnt_d  = LAT_LOAD;
            beat_d     = '0;
            state_d    = S_RSP_WAIT;
          end else begin
            state_d = S_RSP_IDLE;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = S_RSP_IDLE;
    endcase
  end

  assign rsp_state = state_q;

  // ---------------- beat addressing ----------------
  logic [1:0]   beat_num;
  t_ccip_clAddr line_idx;
  logic         beat_in_range;
  t_ccip_clData beat_data;

`ifdef SHA512_RSP_REORDER_EN
  assign beat_num = cur_len_q - beat_q;
`else
  assign beat_num = beat_q;
`endif

  // Full-width arithmetic: addresses below MEM_BASE wrap to huge indices
  // and therefore fall out of range rather than aliasing into the window.
  assign line_idx      = cur_addr_q - MEM_BASE + t_ccip_clAddr'(beat_num);
  assign beat_in_range = (line_idx < LINES_A);
  // Read is taken from the array before this edge's write lands, so a
  // same-cycle write to the same line is not visible in the beat.
  assign beat_data     = beat_in_range ? mem[line_idx[MEM_AW-1:0]] : '0;

  // ---------------- writes ----------------
  t_ccip_clAddr wr_idx;
  logic         wr_in_range;

  assign wr_idx      = ccip_c1_tx.hdr.address - MEM_BASE;
  assign wr_in_range = (wr_idx < LINES_A);

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (ccip_c1_tx.valid && wr_in_range) mem[wr_idx[MEM_AW-1:0]] <= ccip_c1_tx.data;
  end

  logic c1_rsp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RSP_IDLE;
      lat_cnt_q  <= '0;
      cur_addr_q <= '0;
      cur_len_q  <= '0;
      beat_q     <= '0;
      c1_rsp_q   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      cur_addr_q <= cur_addr_d;
      cur_len_q  <= cur_len_d;
      beat_q     <= beat_d;
      c1_rsp_q   <= ccip_c1_tx.valid;
      if ((ccip_c0_tx.valid && fifo_full) ||
          (beat_valid && !beat_in_range) ||
          (ccip_c1_tx.valid && !wr_in_range)) begin
        addr_err <= 1'b1;
      end
    end
  end

  // ---------------- response outputs ----------------
  always_comb begin
    ccip_rx                  = '0;
    ccip_rx.c0TxAlmFull      = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    ccip_rx.c1TxAlmFull      = 1'b0;
    ccip_rx.c0.rspValid      = beat_valid;
    ccip_rx.c0.hdr.resp_type = eRSP_RDLINE;
    ccip_rx.c0.hdr.cl_num    = beat_valid ? beat_num : '0;
    ccip_rx.c0.data          = beat_valid ? beat_data : '0;
    ccip_rx.c1.rspValid      = c1_rsp_q;
    ccip_rx.c1.hdr.resp_type = eRSP_WRLINE;
  end

endmodule

// File: tb/tb_sha512_mem_responder.sv
// tb_sha512_mem_responder -- directed bench for sha512_mem_responder.
// Window base 0x100, 64 lines, RD_LATENCY 2, queue depth 4. Inputs are
// driven 1 ns after the rising edge and outputs are sampled there too.
// Expected burst order follows SHA512_RSP_REORDER_EN when defined.
module tb_sha512_mem_responder;
  import sha512_pkg::*;

  localparam t_ccip_clAddr BASE = 42'h100;
`ifdef SHA512_RSP_REORDER_EN
  localparam bit REORDER = 1'b1;
`else
  localparam bit REORDER = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  t_if_ccip_c0_Tx c0_tx;
  t_if_ccip_c1_Tx c1_tx;
  t_if_ccip_Rx    rx;
  logic           addr_err;
  t_rsp_state     rsp_state;

  sha512_mem_responder #(
    .MEM_BASE   (BASE),
    .MEM_LINES  (64),
    .RD_LATENCY (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ccip_c0_tx (c0_tx),
    .ccip_c1_tx (c1_tx),
    .ccip_rx    (rx),
    .addr_err   (addr_err),
    .rsp_state  (rsp_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [511:0] dat_a, dat_b, dat_c, dat_d, dat_e, dat_f, dat_one;

  // ---------------- scoreboard ----------------
  logic [513:0] exp_q[$];   // {cl_num, data}

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    c0_tx.valid = 1'b0;
    c1_tx.valid = 1'b0;
  endtask

  task automatic drive_rd(input t_ccip_clAddr a, input t_ccip_clLen l);
    c0_tx.valid       = 1'b1;
    c0_tx.hdr.address = a;
    c0_tx.hdr.cl_len  = l;
  endtask

  task automatic drive_wr(input t_ccip_clAddr a, input logic [511:0] d);
    c1_tx.valid       = 1'b1;
    c1_tx.hdr.address = a;
    c1_tx.data        = d;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] num, input logic [511:0] d);
    chk({tag, "_vld"}, rx.c0.rspValid, 1'b1);
    chk({tag, "_type"}, rx.c0.hdr.resp_type, eRSP_RDLINE);
    chk({tag, "_num"}, rx.c0.hdr.cl_num, num);
    chk({tag, "_data"}, rx.c0.data, d);
  endtask

  task automatic drain(input int budget);
    logic [513:0] e;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      if (rx.c0.rspValid) begin
        e = exp_q.pop_front();
        chk("sb_beat", {rx.c0.hdr.cl_num, rx.c0.data}, e);
      end
      tick();
    end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [513:0] burst [4];
    c0_tx   = '0;
    c1_tx   = '0;
    reset   = 1'b1;
    dat_a   = {8{64'h0123_4567_89AB_CDEF}};
    dat_b   = {8{64'hFEDC_BA98_7654_3210}};
    dat_c   = {16{32'hC0DE_0063}};
    dat_d   = {16{32'hD00D_F00D}};
    dat_e   = {16{32'hEEEE_1111}};
    dat_f   = {16{32'h1234_5678}};
    dat_one = 512'h1;

    // Reset values, sampled while reset is still asserted.
    tick();
    tick();
    chk("rst_c0_vld", rx.c0.rspValid, 1'b0);
    chk("rst_c1_vld", rx.c1.rspValid, 1'b0);
    chk("rst_c0_almfull", rx.c0TxAlmFull, 1'b0);
    chk("rst_c1_almfull", rx.c1TxAlmFull, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_state", rsp_state, S_RSP_IDLE);
    reset = 1'b0;
    tick();

    // Preload through c1; each write is acked exactly once, next cycle.
    drive_wr(BASE + 0, dat_a);  tick();
    chk("wr0_ack", rx.c1.rspValid, 1'b1);
    chk("wr0_type", rx.c1.hdr.resp_type, eRSP_WRLINE);
    drive_wr(BASE + 1, dat_b);  tick();
    chk("wr1_ack", rx.c1.rspValid, 1'b1);
    drive_wr(BASE + 2, dat_e);  tick();
    drive_wr(BASE + 3, dat_f);  tick();
    drive_wr(BASE + 63, dat_c); tick();
    chk("wr63_ack", rx.c1.rspValid, 1'b1);
    tick();
    chk("wr_ack_once", rx.c1.rspValid, 1'b0);
    chk("wr_no_err", addr_err, 1'b0);

    // Two-line read at base: beats on cycles +3 and +4.
    drive_rd(BASE, eCL_LEN_2); tick();
    chk("rd2_c1_vld", rx.c0.rspValid, 1'b0);
    tick();
    chk("rd2_c2_vld", rx.c0.rspValid, 1'b0);
    chk("rd2_c2_state", rsp_state, S_RSP_WAIT);
    tick();
    chk_beat("rd2_b0", REORDER ? 2'd1 : 2'd0, REORDER ? dat_b : dat_a);
    tick();
    chk_beat("rd2_b1", REORDER ? 2'd0 : 2'd1, REORDER ? dat_a : dat_b);
    tick();
    chk("rd2_end_vld", rx.c0.rspValid, 1'b0);
    chk("rd2_end_state", rsp_state, S_RSP_IDLE);

    // Write 0x1 to base+1, then read it back.
    drive_wr(BASE + 1, dat_one); tick();
    chk("wr_one_ack", rx.c1.rspValid, 1'b1);
    chk("wr_one_type", rx.c1.hdr.resp_type, eRSP_WRLINE);
    drive_rd(BASE + 1, eCL_LEN_1); tick();
    chk("wr_one_ack_once", rx.c1.rspValid, 1'b0);
    tick();
    tick();
    chk_beat("rd_one", 2'd0, dat_one);

    // Write lands on the same line in the cycle its beat is sent.
    drive_rd(BASE, eCL_LEN_1); tick();
    tick();
    tick();
    drive_wr(BASE, dat_d);
    chk_beat("rw_same_old", 2'd0, dat_a);
    tick();
    chk("rw_same_ack", rx.c1.rspValid, 1'b1);
    chk("rw_same_c0_idle", rx.c0.rspValid, 1'b0);
    drive_rd(BASE, eCL_LEN_1); tick();
    tick();
    tick();
    chk_beat("rw_same_new", 2'd0, dat_d);
    tick();

    // Four-line burst followed back-to-back by a single read.
    burst[0] = {2'd0, dat_d};
    burst[1] = {2'd1, dat_one};
    burst[2] = {2'd2, dat_e};
    burst[3] = {2'd3, dat_f};
    for (int i = 0; i < 4; i++) exp_q.push_back(burst[REORDER ? 3 - i : i]);
    exp_q.push_back({2'd0, dat_c});
    drive_rd(BASE, eCL_LEN_4);      tick();
    drive_rd(BASE + 63, eCL_LEN_1); tick();
    drain(30);
    chk("b2b_no_err", addr_err, 1'b0);

    // Queue fill: R0 keeps the FSM busy, R1..R4 fill the queue, R5 dropped.
    drive_rd(BASE, eCL_LEN_4);     tick();
    drive_rd(BASE + 1, eCL_LEN_1); tick();
    drive_rd(BASE + 1, eCL_LEN_1); tick();
    chk("fill_below_almfull", rx.c0TxAlmFull, 1'b0);
    drive_rd(BASE + 1, eCL_LEN_1); tick();
    chk("fill_almfull", rx.c0TxAlmFull, 1'b1);
    drive_rd(BASE + 1, eCL_LEN_1); tick();
    chk("fill_full_no_err", addr_err, 1'b0);
    drive_rd(BASE + 1, eCL_LEN_1); tick();
    chk("fill_drop_err", addr_err, 1'b1);
    chk("fill_still_almfull", rx.c0TxAlmFull, 1'b1);
    reset = 1'b1; tick();
    chk("fill_rst_vld", rx.c0.rspValid, 1'b0);
    chk("fill_rst_almfull", rx.c0TxAlmFull, 1'b0);
    chk("fill_rst_err", addr_err, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fill_queue_dropped", rx.c0.rspValid, 1'b0);
    end

    // Burst running off the end of the window.
    drive_rd(BASE + 63, eCL_LEN_2); tick();
    tick();
    tick();
    chk_beat("edge_b0", REORDER ? 2'd1 : 2'd0, REORDER ? 512'h0 : dat_c);
    chk("edge_err_early", addr_err, 1'b0);
    tick();
    chk_beat("edge_b1", REORDER ? 2'd0 : 2'd1, REORDER ? dat_c : 512'h0);
    tick();
    chk("edge_err", addr_err, 1'b1);
    chk("edge_end_vld", rx.c0.rspValid, 1'b0);

    // Reset in the middle of a four-line burst.
    drive_rd(BASE, eCL_LEN_4); tick();
    tick();
    tick();
    chk("mid_b0_vld", rx.c0.rspValid, 1'b1);
    tick();
    chk("mid_b1_vld", rx.c0.rspValid, 1'b1);
    reset = 1'b1; tick();
    chk("mid_rst_vld", rx.c0.rspValid, 1'b0);
    chk("mid_rst_state", rsp_state, S_RSP_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_aborted", rx.c0.rspValid, 1'b0);
    end
    chk("mid_err_clear", addr_err, 1'b0);

    // Out-of-window write: still acked, flags addr_err.
    drive_wr(BASE + 64, dat_f); tick();
    chk("oow_wr_ack", rx.c1.rspValid, 1'b1);
    chk("oow_wr_err", addr_err, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
